// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two ALU requesters and alu_share_arbiter.
// Index 0 is the execute stage, index 1 the branch/address-compare unit.
interface alu_share_arbiter_if #(
   parameter int N    = 32,
   parameter int TAGW = 4
);
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [1:0][N-1:0]    req_srca;
   logic [1:0][N-1:0]    req_srcb;
   logic [1:0][2:0]      req_ctrl;
   logic [1:0][TAGW-1:0] req_tag;

   logic [1:0]           rsp_valid;
   logic [1:0]           rsp_ready;
   logic [1:0][N-1:0]    rsp_result;
   logic [1:0]           rsp_zero;
   logic [1:0]           rsp_illegal;
   logic [1:0][TAGW-1:0] rsp_tag;

   modport master (
      output req_valid, req_srca, req_srcb, req_ctrl, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag
   );

   modport slave (
      input  req_valid, req_srca, req_srcb, req_ctrl, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one combinational ALU, 1-cycle registered response per requester.
// Define ALU_ARB_FIXED_PRIO_EN to resolve ties always in favour of req 0 instead of round robin.
module alu_share_arbiter #(
   parameter int N    = 32,
   parameter int TAGW = 4
) (
   input  logic                clk,
   input  logic                reset,
   alu_share_arbiter_if.slave  bus,
   output logic [N-1:0]        alu_srca,
   output logic [N-1:0]        alu_srcb,
   output logic [2:0]          alu_ctrl,
   input  logic [N-1:0]        alu_result,
   input  logic                alu_zero
);

   logic [1:0]           elig;
   logic                 gnt_vld;
   logic                 gnt_idx;
   logic [1:0]           acc;
   logic                 last_grant;
   logic                 illegal;

   logic [1:0]           rsp_valid_q;
   logic [1:0][N-1:0]    rsp_result_q;
   logic [1:0]           rsp_zero_q;
   logic [1:0]           rsp_illegal_q;
   logic [1:0][TAGW-1:0] rsp_tag_q;

   // A requester may issue while its slot is being drained this same cycle.
   assign elig = bus.req_valid & (~rsp_valid_q | bus.rsp_ready);

   always_comb begin
      gnt_vld = |elig;
      gnt_idx = 1'b0;
      case (elig)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
         2'b11:   gnt_idx = 1'b0;
`else
         2'b11:   gnt_idx = ~last_grant;
`endif
         default: gnt_idx = 1'b0;
      endcase
   end

   assign acc = gnt_vld ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

   // Idle drives a quiet ADD 0+0 so the ALU inputs do not toggle.
   assign alu_srca = gnt_vld ? bus.req_srca[gnt_idx] : '0;
   assign alu_srcb = gnt_vld ? bus.req_srcb[gnt_idx] : '0;
   assign alu_ctrl = gnt_vld ? bus.req_ctrl[gnt_idx] : 3'b000;
   assign illegal  = alu_ctrl[2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q   <= '0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= '0;
         rsp_illegal_q <= '0;
         rsp_tag_q     <= '0;
         last_grant    <= 1'b1;
      end else begin
         if (gnt_vld)
            last_grant <= gnt_idx;
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               rsp_valid_q[i]   <= 1'b1;
               rsp_result_q[i]  <= illegal ? '0 : alu_result;
               rsp_zero_q[i]    <= illegal ? 1'b0 : alu_zero;
               rsp_illegal_q[i] <= illegal;
               rsp_tag_q[i]     <= bus.req_tag[i];
            end else if (bus.rsp_ready[i]) begin
               rsp_valid_q[i]   <= 1'b0;
            end
         end
      end
   end

   assign bus.req_ready   = acc;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_zero    = rsp_zero_q;
   assign bus.rsp_illegal = rsp_illegal_q;
   assign bus.rsp_tag     = rsp_tag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the alu_* pins.
// Build with ALU_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority tie rule.
module tb_alu_share_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] alu_srca;
   logic [31:0] alu_srcb;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_result;
   logic        alu_zero;

   int tests_run    = 0;
   int tests_failed = 0;

   alu_share_arbiter_if #(.N(32), .TAGW(4)) bus ();

   alu_share_arbiter #(.N(32), .TAGW(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .alu_srca   (alu_srca),
      .alu_srcb   (alu_srcb),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero)
   );

   // Illegal codes return junk so forcing to zero in the slot is observable.
   always_comb begin
      case (alu_ctrl)
         3'b000:  alu_result = alu_srca + alu_srcb;
         3'b001:  alu_result = alu_srca - alu_srcb;
         3'b010:  alu_result = alu_srca & alu_srcb;
         3'b011:  alu_result = alu_srca | alu_srcb;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
      alu_zero = (alu_srca == alu_srcb);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t);
      bus.req_ctrl[i] = c;
      bus.req_srca[i] = a;
      bus.req_srcb[i] = b;
      bus.req_tag[i]  = t;
   endtask

   initial begin
      logic [1:0] rr_exp [4];
      reset         = 1'b1;
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      set_req(0, 3'b000, 32'd0, 32'd0, 4'd0);
      set_req(1, 3'b000, 32'd0, 32'd0, 4'd0);
      cyc();
      cyc();

      chk("rst_rsp_valid",  64'(bus.rsp_valid), 64'd0);
      chk("rst_result0",    64'(bus.rsp_result[0]), 64'd0);
      chk("rst_tag1",       64'(bus.rsp_tag[1]), 64'd0);
      chk("rst_illegal",    64'(bus.rsp_illegal), 64'd0);
      reset = 1'b0;

      // Fill slot 0 and leave it un-drained, then reset asynchronously.
      bus.req_valid = 2'b01;
      set_req(0, 3'b000, 32'd1, 32'd2, 4'd5);
      #1;
      chk("fill_ready", 64'(bus.req_ready), 64'b01);
      cyc();
      chk("fill_valid",  64'(bus.rsp_valid), 64'b01);
      chk("fill_result", 64'(bus.rsp_result[0]), 64'd3);
      bus.req_valid = 2'b00;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_valid",  64'(bus.rsp_valid), 64'd0);
      chk("async_rst_result", 64'(bus.rsp_result[0]), 64'd0);
      cyc();
      reset = 1'b0;

      // First tie after reset goes to req 0; then round robin under contention.
      bus.rsp_ready = 2'b11;
      bus.req_valid = 2'b11;
      set_req(0, 3'b000, 32'd5, 32'd7, 4'd3);
      set_req(1, 3'b011, 32'hF0, 32'h0F, 4'd9);
      #1;
      chk("tie_after_rst", 64'(bus.req_ready), 64'b01);
      chk("mux_srca",      64'(alu_srca), 64'd5);
      chk("mux_srcb",      64'(alu_srcb), 64'd7);
      chk("mux_ctrl",      64'(alu_ctrl), 64'd0);
      cyc();
      chk("add_valid",  64'(bus.rsp_valid), 64'b01);
      chk("add_result", 64'(bus.rsp_result[0]), 64'd12);
      chk("add_zero",   64'(bus.rsp_zero[0]), 64'd0);
      chk("add_tag",    64'(bus.rsp_tag[0]), 64'd3);

      set_req(0, 3'b010, 32'hFF, 32'h0F, 4'd1);
      set_req(1, 3'b001, 32'd9, 32'd9, 4'd6);
      #1;
      chk("rr_grant1", 64'(bus.req_ready), 64'b10);
      chk("rr_srca1",  64'(alu_srca), 64'd9);
      chk("rr_ctrl1",  64'(alu_ctrl), 64'd1);
      cyc();
      chk("sub_valid",  64'(bus.rsp_valid), 64'b10);
      chk("sub_result", 64'(bus.rsp_result[1]), 64'd0);
      chk("sub_zero",   64'(bus.rsp_zero[1]), 64'd1);
      chk("sub_tag",    64'(bus.rsp_tag[1]), 64'd6);
      #1;
      chk("rr_grant0", 64'(bus.req_ready), 64'b01);
      cyc();
      chk("and_valid",  64'(bus.rsp_valid), 64'b01);
      chk("and_result", 64'(bus.rsp_result[0]), 64'h0F);
      chk("and_zero",   64'(bus.rsp_zero[0]), 64'd0);
      chk("and_tag",    64'(bus.rsp_tag[0]), 64'd1);
      set_req(1, 3'b011, 32'hF0, 32'h0F, 4'd9);
      #1;
      chk("rr_grant1b", 64'(bus.req_ready), 64'b10);
      cyc();
      chk("or_valid",  64'(bus.rsp_valid), 64'b10);
      chk("or_result", 64'(bus.rsp_result[1]), 64'hFF);
      chk("or_tag",    64'(bus.rsp_tag[1]), 64'd9);

      // Backpressure on slot 0: req 1 takes every cycle while req 0 waits.
      bus.rsp_ready = 2'b10;
      set_req(0, 3'b000, 32'd100, 32'd23, 4'd2);
      #1;
      chk("bp_first", 64'(bus.req_ready), 64'b01);
      cyc();
      chk("bp_fill_valid",  64'(bus.rsp_valid), 64'b01);
      chk("bp_fill_result", 64'(bus.rsp_result[0]), 64'd123);
      set_req(0, 3'b001, 32'd50, 32'd8, 4'd4);
      for (int k = 0; k < 3; k++) begin
         set_req(1, 3'b000, 32'(k), 32'd1, 4'(k + 10));
         #1;
         chk("bp_stall_ready", 64'(bus.req_ready), 64'b10);
         cyc();
         chk("bp_r1_result", 64'(bus.rsp_result[1]), 64'(k + 1));
         chk("bp_r1_tag",    64'(bus.rsp_tag[1]), 64'(k + 10));
         chk("bp_slot0_held", 64'(bus.rsp_result[0]), 64'd123);
         chk("bp_valid",      64'(bus.rsp_valid), 64'b11);
      end
      bus.rsp_ready = 2'b11;
      #1;
      chk("refill_ready", 64'(bus.req_ready), 64'b01);
      cyc();
      chk("refill_valid",  64'(bus.rsp_valid), 64'b01);
      chk("refill_result", 64'(bus.rsp_result[0]), 64'd42);
      chk("refill_tag",    64'(bus.rsp_tag[0]), 64'd4);

      bus.req_valid = 2'b00;
      cyc();
      chk("drain_valid", 64'(bus.rsp_valid), 64'b00);
      chk("drain_hold",  64'(bus.rsp_result[0]), 64'd42);

      // Illegal control code from req 1.
      bus.req_valid = 2'b10;
      set_req(1, 3'b100, 32'd1, 32'd1, 4'd7);
      #1;
      chk("ill_ready", 64'(bus.req_ready), 64'b10);
      chk("ill_ctrl",  64'(alu_ctrl), 64'd4);
      cyc();
      chk("ill_valid",  64'(bus.rsp_valid), 64'b10);
      chk("ill_flag",   64'(bus.rsp_illegal[1]), 64'd1);
      chk("ill_result", 64'(bus.rsp_result[1]), 64'd0);
      chk("ill_zero",   64'(bus.rsp_zero[1]), 64'd0);
      chk("ill_tag",    64'(bus.rsp_tag[1]), 64'd7);

      // Lone op from req 0, then idle ALU inputs.
      bus.req_valid = 2'b01;
      set_req(0, 3'b000, 32'd5, 32'd7, 4'd3);
      #1;
      chk("single_ready", 64'(bus.req_ready), 64'b01);
      cyc();
      chk("single_valid",   64'(bus.rsp_valid), 64'b01);
      chk("single_result",  64'(bus.rsp_result[0]), 64'd12);
      chk("single_illegal", 64'(bus.rsp_illegal[0]), 64'd0);
      bus.req_valid = 2'b00;
      #1;
      chk("idle_ready", 64'(bus.req_ready), 64'b00);
      chk("idle_srca",  64'(alu_srca), 64'd0);
      chk("idle_srcb",  64'(alu_srcb), 64'd0);
      chk("idle_ctrl",  64'(alu_ctrl), 64'd0);
      cyc();

      // Four cycles of contention; last grant was req 0.
`ifdef ALU_ARB_FIXED_PRIO_EN
      rr_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
      bus.req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("tie_seq", 64'(bus.req_ready), 64'(rr_exp[k]));
         cyc();
      end
      bus.req_valid = 2'b00;
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
